status_mwr_tx: RTL and testbench
================================

Name: status_mwr_tx

Overview:
- Transmit-side TLP source for the PCIe x1 endpoint core's VC0 transmit interface (16-bit).
- Converts a single status-write request (32-bit address, 32-bit payload) into one 3DW Memory Write TLP with a 1-DW payload.
- Handles posted-credit checks, the tx_req/tx_rdy handshake, stalls and timeout.
- Lets the board logic (LED/counter status) post status words to host memory.

Parameters:
RDY_TIMEOUT, 1024, cycles tx_req may wait for tx_rdy before the request is abandoned (min 2)
TAG_INIT, 0, reset value of the 8-bit tag counter

Ports:
clk  in  1  core clock (125 MHz sys clock domain)
rst  in  1  asynchronous, active-high reset
send  in  1  one-cycle request strobe
addr  in  32  DW-aligned target address; bits [1:0] ignored and sent as 00
data  in  32  payload DW
req_id  in  16  {bus_num, dev_num, func_num} from core config outputs
dl_up  in  1  data link layer up
tx_ca_ph  in  9  available posted header credits
tx_ca_pd  in  13  available posted data credits
tx_rdy  in  1  core grant / beat accept
tx_req  out  1  transmit request to core
tx_st  out  1  first beat marker
tx_end  out  1  last beat marker
tx_data  out  16  TLP beat
busy  out  1  request in progress
done  out  1  one-cycle pulse: TLP fully transferred
timeout  out  1  one-cycle pulse: tx_rdy wait expired
drop_cnt  out  8  saturating count of dropped requests

Behaviour:
- Clock clk; reset rst is asynchronous and active-high.
- Reset: state IDLE; all outputs 0; tag=TAG_INIT; drop_cnt=0. Reset mid-packet aborts immediately; outputs go low asynchronously.
- FSM states: IDLE, WAIT_CRED, REQ, XMIT.
- IDLE:
  - send=1 & dl_up=1: latch addr/data/req_id, go to WAIT_CRED.
  - send=1 & dl_up=0: drop_cnt++.
- WAIT_CRED:
  - dl_up=0: drop_cnt++, go to IDLE.
  - Otherwise, tx_ca_ph>=1 & tx_ca_pd>=1: go to REQ.
  - Otherwise stay.
- REQ:
  - tx_req=1, decoded from the registered state. For a send sampled at edge N with credits available, tx_req is high from cycle N+2.
  - tx_rdy=1: go to XMIT; tx_req=0 from the next cycle.
  - Wait counter reaches RDY_TIMEOUT: tx_req=0, timeout pulse, drop_cnt++, go to IDLE.
  - dl_up is ignored in REQ.
- XMIT:
  - 3-bit beat counter 0..7. The beat is held on tx_data while tx_rdy=0 and advances on each cycle with tx_rdy=1.
  - tx_st=1 on beat 0 only; tx_end=1 on beat 7 only.
  - After beat 7 is accepted: done pulse, tag++ (wraps 0xFF->0x00), go to IDLE. dl_up is ignored once in XMIT.
- Beat order (high half-word first):
  - DW0=0x4000_0001 (fmt 10, type MWr, TC0, length 1)
  - DW1={req_id, tag, 8'h0F} (last BE 0, first BE F)
  - DW2={addr[31:2],2'b00}
  - DW3=payload
- tx_data=0 whenever not in XMIT.
- busy=1 in every state except IDLE.
- send while busy is dropped: drop_cnt++.
- drop_cnt saturates at 0xFF.
- Simultaneous drop events in one cycle count once.

Optional Feature:
- Macro STATUS_MWR_BYTESWAP_EN.
- Defined: the payload DW is byte-swapped, so data[7:0] is the first wire byte (host little-endian view). 0xDEADBEEF is sent as beats 0xEFBE, 0xADDE.
- Undefined: the payload is sent as-is, with data[31:24] as the first byte.
- The header is never swapped.

Test Plan:
- req_id=0x0100, tag=0, addr=0x1000_0043, data=0xDEADBEEF, credits 4/4, tx_rdy asserted the cycle after tx_req -> beats 4000,0001,0100,000F,1000,0040,DEAD,BEEF; tx_st on beat 0, tx_end on beat 7; done pulse; tag becomes 1.
- tx_ca_ph=0 for 20 cycles then 1 -> tx_req stays low while ph=0; asserts 1 cycle after credit appears.
- tx_rdy never asserted, RDY_TIMEOUT=16 -> tx_req high exactly 16 cycles; timeout pulse; drop_cnt=1; busy=0.
- tx_rdy low on beats 3-5 for 2 cycles each -> tx_data held stable during stalls; 8 beats total; packet completes.
- send with dl_up=0, then a second send during busy -> drop_cnt=2. 300 dropped sends -> drop_cnt=0xFF. 256 completed packets -> tag wraps to TAG_INIT.
- rst asserted on beat 4 -> tx_req, tx_st, tx_end, tx_data, busy = 0 immediately. After release, a new send produces a clean 8-beat TLP.

Source files
------------

// File: rtl/status_mwr_tx_if.sv
// ---------------------------------------------------------------------------
// status_mwr_tx_if
//   Bundles the request side (board logic -> status_mwr_tx) and the VC0
//   transmit side (status_mwr_tx <-> PCIe x1 endpoint core) of the status
//   Memory Write TLP source.
//
//   Request side : send, addr[31:0], data[31:0], req_id[15:0]   (to source)
//                  busy, done, timeout, drop_cnt[7:0]           (from source)
//   Core side    : dl_up, tx_ca_ph[8:0], tx_ca_pd[12:0], tx_rdy (to source)
//                  tx_req, tx_st, tx_end, tx_data[15:0]         (from source)
//
//   Handshake: tx_req is held high until the core raises tx_rdy (grant).
//   During the packet, a beat on tx_data is accepted on every rising clk
//   edge where tx_rdy=1; while tx_rdy=0 the beat and its tx_st/tx_end
//   markers are held unchanged.
//
//   Modports: master = the TLP source, slave = the core/board side.
// ---------------------------------------------------------------------------
interface status_mwr_tx_if;
  logic        send;
  logic [31:0] addr;
  logic [31:0] data;
  logic [15:0] req_id;
  logic        dl_up;
  logic [8:0]  tx_ca_ph;
  logic [12:0] tx_ca_pd;
  logic        tx_rdy;
  logic        tx_req;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  drop_cnt;

  modport master (
    input  send, addr, data, req_id, dl_up, tx_ca_ph, tx_ca_pd, tx_rdy,
    output tx_req, tx_st, tx_end, tx_data, busy, done, timeout, drop_cnt
  );

  modport slave (
    output send, addr, data, req_id, dl_up, tx_ca_ph, tx_ca_pd, tx_rdy,
    input  tx_req, tx_st, tx_end, tx_data, busy, done, timeout, drop_cnt
  );
endinterface

// File: rtl/status_mwr_tx.sv
// ---------------------------------------------------------------------------
// status_mwr_tx
//   Turns one status-write request (32-bit address + 32-bit payload) into a
//   3DW Memory Write TLP with a 1-DW payload on the 16-bit VC0 transmit
//   interface of the PCIe x1 endpoint core. Checks posted credits, runs the
//   tx_req/tx_rdy handshake, honours beat stalls and abandons a request whose
//   grant never arrives.
//
//   Parameters:
//     RDY_TIMEOUT : cycles tx_req may stay high without tx_rdy (min 2)
//     TAG_INIT    : reset value of the 8-bit tag counter
//
//   Ports:
//     clk     : core clock (125 MHz)
//     rst     : asynchronous, active-high reset
//     bus     : status_mwr_tx_if.master (request + core transmit signals)
//     o_state : current FSM state (debug)
//
//   Optional build macro:
//     STATUS_MWR_BYTESWAP_EN : byte-swap the payload DW so data[7:0] is the
//                              first byte on the wire. The header is never
//                              swapped.
//
//   Beat order (high half-word first): DW0 = 0x4000_0001,
//   DW1 = {req_id, tag, 8'h0F}, DW2 = {addr[31:2], 2'b00}, DW3 = payload.
// ---------------------------------------------------------------------------
module status_mwr_tx #(
  parameter int          RDY_TIMEOUT = 1024,
  parameter logic [7:0]  TAG_INIT    = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  status_mwr_tx_if.master bus,
  output logic [1:0]      o_state
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_CRED = 2'd1;
  localparam logic [1:0] S_REQ       = 2'd2;
  localparam logic [1:0] S_XMIT      = 2'd3;

  localparam int WCW = $clog2(RDY_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RDY_TIMEOUT - 1);

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [2:0]     r_beat;
  logic [WCW-1:0] r_wait;
  logic [7:0]     r_tag;
  logic [31:0]    r_addr;
  logic [31:0]    r_data;
  logic [15:0]    r_req_id;
  logic           r_done;
  logic           r_timeout;
  logic [7:0]     r_drop_cnt;

  logic           w_cred_ok;
  logic           w_tmo;
  logic           w_last;
  logic           w_accept;
  logic           w_drop;
  logic [31:0]    w_payload;
  logic [15:0]    w_beat_data;

  assign w_cred_ok = (bus.tx_ca_ph != 9'd0) && (bus.tx_ca_pd != 13'd0);
  assign w_tmo     = (r_state == S_REQ) && !bus.tx_rdy && (r_wait == WAIT_LAST);
  assign w_last    = (r_state == S_XMIT) && bus.tx_rdy && (r_beat == 3'd7);
  assign w_accept  = (r_state == S_IDLE) && bus.send && bus.dl_up;

  // All drop sources in one cycle collapse into a single increment.
  always_comb begin
    w_drop = 1'b0;
    case (r_state)
      S_IDLE:      w_drop = bus.send && !bus.dl_up;
      S_WAIT_CRED: w_drop = bus.send || !bus.dl_up;
      S_REQ:       w_drop = bus.send || w_tmo;
      S_XMIT:      w_drop = bus.send;
      default:     w_drop = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WAIT_CRED;
      end
      S_WAIT_CRED: begin
        if (!bus.dl_up)     w_state_nxt = S_IDLE;
        else if (w_cred_ok) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // dl_up deliberately not looked at once the request is raised.
        if (bus.tx_rdy)  w_state_nxt = S_XMIT;
        else if (w_tmo)  w_state_nxt = S_IDLE;
      end
      S_XMIT: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= 3'd0;
      r_wait     <= '0;
      r_tag      <= TAG_INIT;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_req_id   <= 16'd0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_last;
      r_timeout <= w_tmo;

      if (w_accept) begin
        r_addr   <= {bus.addr[31:2], 2'b00};
        r_data   <= bus.data;
        r_req_id <= bus.req_id;
      end

      // Wait counter is cleared outside REQ so every entry starts from 0.
      if (r_state == S_REQ) r_wait <= r_wait + WCW'(1);
      else                  r_wait <= '0;

      if (r_state != S_XMIT)  r_beat <= 3'd0;
      else if (bus.tx_rdy)    r_beat <= r_beat + 3'd1;

      if (w_last) r_tag <= r_tag + 8'd1;

      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

`ifdef STATUS_MWR_BYTESWAP_EN
  assign w_payload = {r_data[7:0], r_data[15:8], r_data[23:16], r_data[31:24]};
`else
  assign w_payload = r_data;
`endif

  always_comb begin
    w_beat_data = 16'h0000;
    case (r_beat)
      3'd0:    w_beat_data = 16'h4000;
      3'd1:    w_beat_data = 16'h0001;
      3'd2:    w_beat_data = r_req_id;
      3'd3:    w_beat_data = {r_tag, 8'h0F};
      3'd4:    w_beat_data = r_addr[31:16];
      3'd5:    w_beat_data = r_addr[15:0];
      3'd6:    w_beat_data = w_payload[31:16];
      3'd7:    w_beat_data = w_payload[15:0];
      default: w_beat_data = 16'h0000;
    endcase
  end

  // Handshake outputs decode straight from the registered state so an
  // asynchronous reset drops them without waiting for a clock edge.
  assign bus.tx_req   = (r_state == S_REQ);
  assign bus.tx_st    = (r_state == S_XMIT) && (r_beat == 3'd0);
  assign bus.tx_end   = (r_state == S_XMIT) && (r_beat == 3'd7);
  assign bus.tx_data  = (r_state == S_XMIT) ? w_beat_data : 16'h0000;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.timeout  = r_timeout;
  assign bus.drop_cnt = r_drop_cnt;
  assign o_state      = r_state;

endmodule

// File: tb/tb_status_mwr_tx.sv
// ---------------------------------------------------------------------------
// tb_status_mwr_tx
//   Directed bench for status_mwr_tx (RDY_TIMEOUT=16, TAG_INIT=0).
//   Inputs change 1 ns after each rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_status_mwr_tx;

  localparam int         TMO   = 16;
  localparam logic [7:0] TINIT = 8'h00;

  logic       clk;
  logic       rst;
  logic [1:0] o_state;

  status_mwr_tx_if bus ();

  status_mwr_tx #(
    .RDY_TIMEOUT (TMO),
    .TAG_INIT    (TINIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (o_state)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] exp_tag;
  logic [7:0] exp_drop;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---- reference model of the TLP beats ----------------------------------
  function automatic logic [15:0] exp_beat(input int i, input logic [15:0] rid,
                                           input logic [7:0] tg, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] p;
`ifdef STATUS_MWR_BYTESWAP_EN
    p = {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    p = d;
`endif
    case (i)
      0: return 16'h4000;
      1: return 16'h0001;
      2: return rid;
      3: return {tg, 8'h0F};
      4: return a[31:16];
      5: return {a[15:2], 2'b00};
      6: return p[31:16];
      default: return p[15:0];
    endcase
  endfunction

  // ---- driver tasks -------------------------------------------------------
  // Drives the 8 beats starting in XMIT at beat 0 with tx_rdy already high.
  // With stall set, tx_rdy drops for 2 cycles on beats 3, 4 and 5.
  task automatic xmit_beats(input logic [15:0] rid, input logic [31:0] a,
                            input logic [31:0] d, input bit stall);
    logic [15:0] eb;
    for (int i = 0; i < 8; i++) begin
      eb = exp_beat(i, rid, exp_tag, a, d);
      if (stall && i >= 3 && i <= 5) begin
        bus.tx_rdy = 1'b0;
        for (int s = 0; s < 2; s++) begin
          chk($sformatf("stall_data_b%0d", i), bus.tx_data, eb);
          tick();
        end
        bus.tx_rdy = 1'b1;
      end
      chk($sformatf("beat%0d", i), bus.tx_data, eb);
      chk($sformatf("tx_st_b%0d", i), bus.tx_st, (i == 0));
      chk($sformatf("tx_end_b%0d", i), bus.tx_end, (i == 7));
      chk($sformatf("tx_req_b%0d", i), bus.tx_req, 1'b0);
      tick();
    end
    chk("done_pulse", bus.done, 1'b1);
    chk("busy_after", bus.busy, 1'b0);
    bus.tx_rdy = 1'b0;
    exp_tag = exp_tag + 8'd1;
    tick();
    chk("done_clear", bus.done, 1'b0);
  endtask

  task automatic run_pkt(input logic [15:0] rid, input logic [31:0] a,
                         input logic [31:0] d, input bit stall);
    bus.req_id = rid;
    bus.addr   = a;
    bus.data   = d;
    bus.send   = 1'b1;
    tick();
    bus.send   = 1'b0;
    chk("busy_wait", bus.busy, 1'b1);
    chk("no_req_yet", bus.tx_req, 1'b0);
    tick();
    chk("tx_req_up", bus.tx_req, 1'b1);
    bus.tx_rdy = 1'b1;
    tick();
    xmit_beats(rid, a, d, stall);
  endtask

  // ---- directed sequence --------------------------------------------------
  initial begin
    int cnt;
    rst          = 1'b1;
    bus.send     = 1'b0;
    bus.addr     = 32'd0;
    bus.data     = 32'd0;
    bus.req_id   = 16'd0;
    bus.dl_up    = 1'b0;
    bus.tx_ca_ph = 9'd0;
    bus.tx_ca_pd = 13'd0;
    bus.tx_rdy   = 1'b0;
    exp_tag      = TINIT;
    exp_drop     = 8'd0;
    repeat (3) tick();

    chk("rst_state", o_state, 2'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_tx_req", bus.tx_req, 1'b0);
    chk("rst_tx_data", bus.tx_data, 16'h0000);
    chk("rst_drop", bus.drop_cnt, 8'h00);
    rst = 1'b0;
    tick();

    // Basic packet with the documented vector.
    bus.dl_up    = 1'b1;
    bus.tx_ca_ph = 9'd4;
    bus.tx_ca_pd = 13'd4;
    run_pkt(16'h0100, 32'h1000_0043, 32'hDEAD_BEEF, 1'b0);

    // Header credit missing for 20 cycles: tag is now 1 (checked in beat 3).
    bus.tx_ca_ph = 9'd0;
    bus.req_id   = 16'h0100;
    bus.addr     = 32'h2000_0008;
    bus.data     = 32'h1234_5678;
    bus.send     = 1'b1;
    tick();
    bus.send     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("cred_hold_req", bus.tx_req, 1'b0);
      tick();
    end
    chk("cred_hold_state", o_state, 2'd1);
    bus.tx_ca_ph = 9'd1;
    tick();
    chk("cred_req_up", bus.tx_req, 1'b1);
    bus.tx_rdy = 1'b1;
    tick();
    xmit_beats(16'h0100, 32'h2000_0008, 32'h1234_5678, 1'b0);

    // tx_rdy never arrives: tx_req lasts exactly RDY_TIMEOUT cycles.
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    tick();
    cnt = 0;
    while (bus.tx_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_req_cycles", cnt, TMO);
    exp_drop = exp_drop + 8'd1;
    chk("tmo_pulse", bus.timeout, 1'b1);
    chk("tmo_drop", bus.drop_cnt, exp_drop);
    chk("tmo_busy", bus.busy, 1'b0);
    tick();
    chk("tmo_pulse_clear", bus.timeout, 1'b0);

    // Stalls on beats 3..5.
    run_pkt(16'hABCD, 32'hFEDC_BA9B, 32'h0BAD_F00D, 1'b1);

    // Send with link down, then send while busy.
    bus.dl_up = 1'b0;
    bus.send  = 1'b1;
    tick();
    bus.send  = 1'b0;
    exp_drop  = exp_drop + 8'd1;
    chk("drop_dl_down", bus.drop_cnt, exp_drop);
    chk("drop_dl_idle", bus.busy, 1'b0);
    bus.dl_up    = 1'b1;
    bus.tx_ca_ph = 9'd0;
    bus.send     = 1'b1;
    tick();
    chk("drop_busy_before", bus.drop_cnt, exp_drop);
    tick();
    bus.send = 1'b0;
    exp_drop = exp_drop + 8'd1;
    chk("drop_busy", bus.drop_cnt, exp_drop);
    // Link loss while waiting for credit abandons the request.
    bus.dl_up = 1'b0;
    tick();
    exp_drop = exp_drop + 8'd1;
    chk("drop_waitcred", bus.drop_cnt, exp_drop);
    chk("drop_waitcred_idle", o_state, 2'd0);

    // 300 dropped sends saturate the counter.
    bus.send = 1'b1;
    repeat (300) tick();
    bus.send = 1'b0;
    chk("drop_saturate", bus.drop_cnt, 8'hFF);

    // Reset in the middle of beat 4.
    bus.dl_up    = 1'b1;
    bus.tx_ca_ph = 9'd2;
    bus.req_id   = 16'h5A5A;
    bus.addr     = 32'h3000_0010;
    bus.data     = 32'hCAFE_0001;
    bus.send     = 1'b1;
    tick();
    bus.send     = 1'b0;
    tick();
    bus.tx_rdy   = 1'b1;
    repeat (5) tick();
    chk("pre_rst_beat4", bus.tx_data, exp_beat(4, 16'h5A5A, exp_tag, 32'h3000_0010, 32'hCAFE_0001));
    rst = 1'b1;
    #1;
    chk("arst_tx_req", bus.tx_req, 1'b0);
    chk("arst_tx_st", bus.tx_st, 1'b0);
    chk("arst_tx_end", bus.tx_end, 1'b0);
    chk("arst_tx_data", bus.tx_data, 16'h0000);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_drop", bus.drop_cnt, 8'h00);
    bus.tx_rdy = 1'b0;
    tick();
    rst      = 1'b0;
    exp_tag  = TINIT;
    exp_drop = 8'd0;
    tick();
    run_pkt(16'h0203, 32'h4000_0004, 32'h0102_0304, 1'b0);

    // 256 packets bring the tag back around; the next packet shows it in beat 3.
    for (int k = 0; k < 256; k++)
      run_pkt(16'(k), 32'h5000_0000 + 32'(k * 4), 32'(k) ^ 32'hA5A5_5A5A, 1'b0);
    chk("tag_wrap_model", exp_tag, 8'(TINIT + 8'd1));
    run_pkt(16'h0100, 32'h1000_0043, 32'hDEAD_BEEF, 1'b0);
    chk("final_drop", bus.drop_cnt, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
